// File: rtl/tdes_cbc_ctrl.sv
// CBC chaining front-end for the tdes core: applies IV/chain XORs around one block at a
// time, drives the core handshake and returns chained results on a valid/ready stream.
module tdes_cbc_ctrl #(
    parameter bit CBC_EN  = 1'b1,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mode_i,
    input  logic        start_i,
    input  logic [63:0] iv_i,
    input  logic [63:0] key1_i,
    input  logic [63:0] key2_i,
    input  logic [63:0] key3_i,
    input  logic [63:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [63:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        err_o,
    output logic        des_mode_o,
    output logic [63:0] des_key1_o,
    output logic [63:0] des_key2_o,
    output logic [63:0] des_key3_o,
    output logic [63:0] des_data_o,
    output logic        des_valid_o,
    input  logic [63:0] des_data_i,
    input  logic        des_valid_i,
    input  logic        des_ready_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_q;
    logic          mode_q;
    logic [63:0]   key1_q, key2_q, key3_q;
    logic [63:0]   chain_q, chainUse_q, inBlock_q;
    logic [63:0]   desData_q, dataOut_q;
    logic          desValid_q, validOut_q, err_q;
    logic [CW-1:0] timer_q;

    logic [63:0]   chainUse_d, desData_d, result_d;

    // Encrypt XORs the chain before the core, decrypt XORs it after the core.
    always_comb begin
        chainUse_d = start_i ? iv_i : chain_q;
        desData_d  = (!mode_i && CBC_EN) ? (data_i ^ chainUse_d) : data_i;
        result_d   = (mode_q && CBC_EN) ? (des_data_i ^ chainUse_q) : des_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            key1_q     <= '0;
            key2_q     <= '0;
            key3_q     <= '0;
            chain_q    <= '0;
            chainUse_q <= '0;
            inBlock_q  <= '0;
            desData_q  <= '0;
            dataOut_q  <= '0;
            desValid_q <= 1'b0;
            validOut_q <= 1'b0;
            err_q      <= 1'b0;
            timer_q    <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        mode_q     <= mode_i;
                        key1_q     <= key1_i;
                        key2_q     <= key2_i;
                        key3_q     <= key3_i;
                        inBlock_q  <= data_i;
                        chainUse_q <= chainUse_d;
                        desData_q  <= desData_d;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (des_ready_i) begin
                        desValid_q <= 1'b1;
                        timer_q    <= '0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    desValid_q <= 1'b0;
                    if (des_valid_i) begin
                        dataOut_q  <= result_d;
                        chain_q    <= mode_q ? inBlock_q : des_data_i;
                        validOut_q <= 1'b1;
                        state_q    <= OUT;
                    end else if (timer_q == CW'(TIMEOUT - 1)) begin
                        // Core never answered: drop the block and leave the chain untouched.
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                OUT: begin
                    if (ready_i) begin
                        validOut_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o     = (state_q == IDLE);
    assign data_o      = dataOut_q;
    assign valid_o     = validOut_q;
    assign err_o       = err_q;
    assign des_mode_o  = mode_q;
    assign des_key1_o  = key1_q;
    assign des_key2_o  = key2_q;
    assign des_key3_o  = key3_q;
    assign des_data_o  = desData_q;
    assign des_valid_o = desValid_q;

endmodule

// File: tb/tb_tdes_cbc_ctrl.sv
// Directed bench for tdes_cbc_ctrl; a lookup-table stand-in for the tdes core answers
// with the single-DES (key 0123456789ABCDEF) results of the FIPS-81 CBC example.
module tb_tdes_cbc_ctrl;

    localparam logic [63:0] P1  = 64'h4E6F772069732074;
    localparam logic [63:0] P2  = 64'h68652074696D6520;
    localparam logic [63:0] P3  = 64'h666F7220616C6C20;
    localparam logic [63:0] IV  = 64'h1234567890ABCDEF;
    localparam logic [63:0] C1  = 64'hE5C7CDDE872BF27C;
    localparam logic [63:0] C2  = 64'h43E934008C389C0F;
    localparam logic [63:0] C3  = 64'h683788499A7C05F6;
    localparam logic [63:0] EC1 = 64'h3FA40E8A984D4815;
    localparam logic [63:0] KEY = 64'h0123456789ABCDEF;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        modeIn = 1'b0, startIn = 1'b0, validIn = 1'b0, readyIn = 1'b1, validE = 1'b0;
    logic        coreReady = 1'b1, coreStall = 1'b0;
    logic [63:0] ivIn = IV, keyIn = KEY, dataIn = '0;

    logic        readyO, validO, errO, desModeO, desValidO;
    logic [63:0] dataO, desKey1O, desKey2O, desKey3O, desDataO;
    logic [63:0] desDataI = '0;
    logic        desValidI = 1'b0;

    logic        readyOE, validOE, errOE, desModeOE, desValidOE;
    logic [63:0] dataOE, desKey1OE, desKey2OE, desKey3OE, desDataOE;
    logic [63:0] desDataIE = '0;
    logic        desValidIE = 1'b0;

    logic [63:0] tIn [8];
    logic [63:0] tOut [8];
    logic        tMode [8];

    logic        pend0 = 1'b0, pend1 = 1'b0;
    logic [63:0] pendD0 = '0, pendD1 = '0;
    logic [2:0]  cnt0 = '0, cnt1 = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tdes_cbc_ctrl #(.CBC_EN(1'b1), .TIMEOUT(16)) dut (
        .clk_i(clk), .reset_i(resetN), .mode_i(modeIn), .start_i(startIn), .iv_i(ivIn),
        .key1_i(keyIn), .key2_i(keyIn), .key3_i(keyIn), .data_i(dataIn), .valid_i(validIn),
        .ready_o(readyO), .data_o(dataO), .valid_o(validO), .ready_i(readyIn), .err_o(errO),
        .des_mode_o(desModeO), .des_key1_o(desKey1O), .des_key2_o(desKey2O),
        .des_key3_o(desKey3O), .des_data_o(desDataO), .des_valid_o(desValidO),
        .des_data_i(desDataI), .des_valid_i(desValidI), .des_ready_i(coreReady)
    );

    tdes_cbc_ctrl #(.CBC_EN(1'b0), .TIMEOUT(16)) dutEcb (
        .clk_i(clk), .reset_i(resetN), .mode_i(modeIn), .start_i(startIn), .iv_i(ivIn),
        .key1_i(keyIn), .key2_i(keyIn), .key3_i(keyIn), .data_i(dataIn), .valid_i(validE),
        .ready_o(readyOE), .data_o(dataOE), .valid_o(validOE), .ready_i(1'b1), .err_o(errOE),
        .des_mode_o(desModeOE), .des_key1_o(desKey1OE), .des_key2_o(desKey2OE),
        .des_key3_o(desKey3OE), .des_data_o(desDataOE), .des_valid_o(desValidOE),
        .des_data_i(desDataIE), .des_valid_i(desValidIE), .des_ready_i(coreReady)
    );

    // Unknown core inputs come back inverted so a wrong chaining XOR is visible downstream.
    function automatic logic [63:0] coreFn(input logic [63:0] d, input logic m);
        for (int i = 0; i < 8; i++)
            if (tIn[i] == d && tMode[i] == m) return tOut[i];
        return ~d;
    endfunction

    always @(posedge clk) begin
        desValidI <= 1'b0;
        if (desValidO && !coreStall) begin
            pend0  <= 1'b1;
            pendD0 <= coreFn(desDataO, desModeO);
            cnt0   <= 3'd2;
        end else if (pend0) begin
            if (cnt0 == 3'd0) begin
                desValidI <= 1'b1;
                desDataI  <= pendD0;
                pend0     <= 1'b0;
            end else cnt0 <= cnt0 - 3'd1;
        end
    end

    always @(posedge clk) begin
        desValidIE <= 1'b0;
        if (desValidOE && !coreStall) begin
            pend1  <= 1'b1;
            pendD1 <= coreFn(desDataOE, desModeOE);
            cnt1   <= 3'd2;
        end else if (pend1) begin
            if (cnt1 == 3'd0) begin
                desValidIE <= 1'b1;
                desDataIE  <= pendD1;
                pend1      <= 1'b0;
            end else cnt1 <= cnt1 - 3'd1;
        end
    end

    task automatic sendOnly(input logic [63:0] d, input logic s, input logic m);
        @(negedge clk);
        dataIn = d; startIn = s; modeIn = m; validIn = 1'b1;
        for (int i = 0; i < 50 && !readyO; i++) @(negedge clk);
        @(negedge clk);
        validIn = 1'b0;
    endtask

    task automatic runBlock(input logic [63:0] d, input logic s, input logic m,
                            output logic [63:0] res);
        res = 64'hx;
        sendOnly(d, s, m);
        for (int i = 0; i < 60; i++) begin
            if (validO) begin
                res = dataO;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (readyO !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", readyO); end
        checks++; if (validO !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", validO); end
        checks++; if (dataO !== 64'h0) begin errors++; $display("[TB] FAIL reset_data got=%h exp=0", dataO); end
        checks++; if (desValidO !== 1'b0 || errO !== 1'b0 || desModeO !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_ctrl got=%b%b%b exp=000", desValidO, errO, desModeO); end
        checks++; if (desDataO !== 64'h0 || desKey1O !== 64'h0) begin
            errors++; $display("[TB] FAIL reset_desbus got=%h/%h exp=0/0", desDataO, desKey1O); end
        resetN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cbc_enc;
        logic [63:0] r;
        runBlock(P1, 1'b1, 1'b0, r);
        checks++; if (r !== C1) begin errors++; $display("[TB] FAIL enc_blk1 got=%h exp=%h", r, C1); end
        runBlock(P2, 1'b0, 1'b0, r);
        checks++; if (r !== C2) begin errors++; $display("[TB] FAIL enc_blk2 got=%h exp=%h", r, C2); end
        runBlock(P3, 1'b0, 1'b0, r);
        checks++; if (r !== C3) begin errors++; $display("[TB] FAIL enc_blk3 got=%h exp=%h", r, C3); end
    endtask

    task automatic test_cbc_dec;
        logic [63:0] r;
        runBlock(C1, 1'b1, 1'b1, r);
        checks++; if (r !== P1) begin errors++; $display("[TB] FAIL dec_blk1 got=%h exp=%h", r, P1); end
        runBlock(C2, 1'b0, 1'b1, r);
        checks++; if (r !== P2) begin errors++; $display("[TB] FAIL dec_blk2 got=%h exp=%h", r, P2); end
        runBlock(C3, 1'b0, 1'b1, r);
        checks++; if (r !== P3) begin errors++; $display("[TB] FAIL dec_blk3 got=%h exp=%h", r, P3); end
    endtask

    task automatic test_mode_switch;
        logic [63:0] r;
        runBlock(P1, 1'b1, 1'b0, r);
        checks++; if (r !== C1) begin errors++; $display("[TB] FAIL switch_enc got=%h exp=%h", r, C1); end
        runBlock(C2, 1'b0, 1'b1, r);
        checks++; if (r !== P2) begin errors++; $display("[TB] FAIL switch_dec got=%h exp=%h", r, P2); end
    endtask

    task automatic test_issue_hold;
        logic [63:0] r;
        r = 64'hx;
        coreReady = 1'b0;
        sendOnly(P1, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        checks++; if (desValidO !== 1'b0) begin errors++; $display("[TB] FAIL hold_novalid got=%b exp=0", desValidO); end
        checks++; if (desDataO !== (P1 ^ IV)) begin errors++; $display("[TB] FAIL hold_data got=%h exp=%h", desDataO, P1 ^ IV); end
        checks++; if (desKey3O !== KEY || desModeO !== 1'b0) begin
            errors++; $display("[TB] FAIL hold_key got=%h/%b exp=%h/0", desKey3O, desModeO, KEY); end
        checks++; if (readyO !== 1'b0) begin errors++; $display("[TB] FAIL hold_busy got=%b exp=0", readyO); end
        coreReady = 1'b1;
        @(negedge clk);
        checks++; if (desValidO !== 1'b1) begin errors++; $display("[TB] FAIL issue_pulse got=%b exp=1", desValidO); end
        @(negedge clk);
        checks++; if (desValidO !== 1'b0) begin errors++; $display("[TB] FAIL issue_once got=%b exp=0", desValidO); end
        for (int i = 0; i < 30; i++) begin
            if (validO) begin r = dataO; break; end
            @(negedge clk);
        end
        checks++; if (r !== C1) begin errors++; $display("[TB] FAIL hold_result got=%h exp=%h", r, C1); end
    endtask

    task automatic test_backpressure;
        int bad;
        bad = 0;
        readyIn = 1'b0;
        sendOnly(P1, 1'b1, 1'b0);
        for (int i = 0; i < 30 && !validO; i++) @(negedge clk);
        dataIn = P2; startIn = 1'b0; validIn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (validO !== 1'b1 || dataO !== C1 || readyO !== 1'b0 || desValidO !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL bp_stable got=%0d bad cycles exp=0 (data=%h)", bad, dataO); end
        validIn = 1'b0;
        readyIn = 1'b1;
        @(negedge clk);
        checks++; if (validO !== 1'b0 || readyO !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_release got=%b%b exp=01", validO, readyO); end
    endtask

    task automatic test_ecb;
        logic [63:0] r;
        for (int blk = 0; blk < 2; blk++) begin
            r = 64'hx;
            @(negedge clk);
            dataIn = P1; startIn = (blk == 0); modeIn = 1'b0; validE = 1'b1;
            for (int i = 0; i < 50 && !readyOE; i++) @(negedge clk);
            @(negedge clk);
            validE = 1'b0;
            for (int i = 0; i < 60; i++) begin
                if (validOE) begin r = dataOE; break; end
                @(negedge clk);
            end
            checks++; if (r !== EC1) begin errors++; $display("[TB] FAIL ecb_blk%0d got=%h exp=%h", blk, r, EC1); end
        end
    endtask

    task automatic test_timeout;
        logic [63:0] r;
        int n;
        runBlock(P1, 1'b1, 1'b0, r);
        coreStall = 1'b1;
        sendOnly(P3, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !desValidO; i++) @(negedge clk);
        n = 0;
        while (!errO && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 16) begin errors++; $display("[TB] FAIL timeout_cycles got=%0d exp=16", n); end
        checks++; if (readyO !== 1'b1 || validO !== 1'b0) begin
            errors++; $display("[TB] FAIL timeout_idle got=%b%b exp=10", readyO, validO); end
        @(negedge clk);
        checks++; if (errO !== 1'b0) begin errors++; $display("[TB] FAIL timeout_pulse got=%b exp=0", errO); end
        coreStall = 1'b0;
        runBlock(P2, 1'b0, 1'b0, r);
        checks++; if (r !== C2) begin errors++; $display("[TB] FAIL timeout_chain got=%h exp=%h", r, C2); end
    endtask

    task automatic test_reset_mid;
        logic [63:0] r;
        int seen;
        sendOnly(P1, 1'b1, 1'b0);
        for (int i = 0; i < 20 && !desValidO; i++) @(negedge clk);
        @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        checks++; if (readyO !== 1'b1 || validO !== 1'b0 || desValidO !== 1'b0 || errO !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_ctrl got=%b%b%b%b exp=1000", readyO, validO, desValidO, errO); end
        checks++; if (dataO !== 64'h0 || desDataO !== 64'h0 || desKey1O !== 64'h0) begin
            errors++; $display("[TB] FAIL midreset_data got=%h/%h/%h exp=0", dataO, desDataO, desKey1O); end
        resetN = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (validO !== 1'b0 || readyO !== 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("[TB] FAIL midreset_late got=%0d exp=0", seen); end
        runBlock(P1, 1'b1, 1'b0, r);
        checks++; if (r !== C1) begin errors++; $display("[TB] FAIL midreset_next got=%h exp=%h", r, C1); end
    endtask

    initial begin
        tIn[0] = P1 ^ IV; tMode[0] = 1'b0; tOut[0] = C1;
        tIn[1] = P2 ^ C1; tMode[1] = 1'b0; tOut[1] = C2;
        tIn[2] = P3 ^ C2; tMode[2] = 1'b0; tOut[2] = C3;
        tIn[3] = C1;      tMode[3] = 1'b1; tOut[3] = P1 ^ IV;
        tIn[4] = C2;      tMode[4] = 1'b1; tOut[4] = P2 ^ C1;
        tIn[5] = C3;      tMode[5] = 1'b1; tOut[5] = P3 ^ C2;
        tIn[6] = P1;      tMode[6] = 1'b0; tOut[6] = EC1;
        tIn[7] = '0;      tMode[7] = 1'b1; tOut[7] = 64'hDEADBEEFDEADBEEF;
        test_reset();
        test_cbc_enc();
        test_cbc_dec();
        test_mode_switch();
        test_issue_hold();
        test_backpressure();
        test_ecb();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
